// File: rtl/rel_compare_tracker.sv
// ---------------------------------------------------------------------------
// rel_compare_tracker
//
// Pipelined relational compare of an operand stream, with running statistics.
// Each accepted pair (a, b) is compared and the result is held in a
// single-entry output register (gt/lt/eq flags plus per-pair max/min).
// Alongside, a two-state machine (EMPTY / TRACKING) keeps saturating counts of
// gt/lt/eq outcomes and the running extremes since the last clear.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both high. valid may not depend on ready; once a result
// is presented it stays stable until out_ready is seen high. in_ready is
// combinational: !out_valid || out_ready, so a new pair may be accepted in the
// same cycle the held result is consumed (full throughput, 1-cycle latency).
//
// Parameters:
//   WIDTH  - operand width (>= 2)
//   SIGNED - 0: unsigned compare, 1: two's-complement compare
//   CNT_W  - width of each outcome counter
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - operand pair handshake, a/b operands
//   clear                 - synchronous clear of statistics only
//   out_valid/out_ready   - result handshake
//   gt, lt, eq            - relation of the held pair
//   max_ab, min_ab        - larger / smaller operand of the held pair
//   run_max, run_min      - extremes since clear
//   gt_cnt, lt_cnt, eq_cnt- saturating outcome counts since clear
//   stats_valid           - statistics state is TRACKING (>=1 pair since clear)
// ---------------------------------------------------------------------------
module rel_compare_tracker #(
   parameter int WIDTH  = 8,
   parameter int SIGNED = 0,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt,
   output logic             lt,
   output logic             eq,
   output logic [WIDTH-1:0] max_ab,
   output logic [WIDTH-1:0] min_ab,
   output logic [WIDTH-1:0] run_max,
   output logic [WIDTH-1:0] run_min,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic             stats_valid
);

   typedef enum logic {
      EMPTY    = 1'b0,
      TRACKING = 1'b1
   } state_t;

   state_t state;

   // Flipping the sign bit maps two's-complement order onto unsigned order,
   // so one unsigned comparator serves both modes.
   localparam logic [WIDTH-1:0] BIAS = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

   function automatic logic greater(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      return (x ^ BIAS) > (y ^ BIAS);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + CNT_W'(1);
   endfunction

   logic             accept;
   logic             a_gt_b;
   logic             a_lt_b;
   logic             a_eq_b;
   logic [WIDTH-1:0] pair_max;
   logic [WIDTH-1:0] pair_min;
   logic             have_prev;
   logic [WIDTH-1:0] next_max;
   logic [WIDTH-1:0] next_min;
   logic [CNT_W-1:0] gt_base;
   logic [CNT_W-1:0] lt_base;
   logic [CNT_W-1:0] eq_base;

   assign in_ready    = !out_valid || out_ready;
   assign accept      = in_valid && in_ready;
   assign stats_valid = (state == TRACKING);

   always_comb begin
      a_gt_b   = greater(a, b);
      a_lt_b   = greater(b, a);
      a_eq_b   = (a == b);
      pair_max = a_gt_b ? a : b;
      pair_min = a_gt_b ? b : a;
      // A clear in the same cycle makes the incoming pair the first one.
      have_prev = (state == TRACKING) && !clear;
      next_max  = (have_prev && greater(run_max, pair_max)) ? run_max : pair_max;
      next_min  = (have_prev && greater(pair_min, run_min)) ? run_min : pair_min;
      gt_base   = clear ? '0 : gt_cnt;
      lt_base   = clear ? '0 : lt_cnt;
      eq_base   = clear ? '0 : eq_cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         gt        <= 1'b0;
         lt        <= 1'b0;
         eq        <= 1'b0;
         max_ab    <= '0;
         min_ab    <= '0;
         run_max   <= '0;
         run_min   <= '0;
         gt_cnt    <= '0;
         lt_cnt    <= '0;
         eq_cnt    <= '0;
      end else begin
         // Result register
         if (accept) begin
            out_valid <= 1'b1;
            gt        <= a_gt_b;
            lt        <= a_lt_b;
            eq        <= a_eq_b;
            max_ab    <= pair_max;
            min_ab    <= pair_min;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         // Statistics state machine
         if (accept) begin
            state   <= TRACKING;
            run_max <= next_max;
            run_min <= next_min;
            gt_cnt  <= a_gt_b ? sat_inc(gt_base) : gt_base;
            lt_cnt  <= a_lt_b ? sat_inc(lt_base) : lt_base;
            eq_cnt  <= a_eq_b ? sat_inc(eq_base) : eq_base;
         end else if (clear) begin
            state   <= EMPTY;
            run_max <= '0;
            run_min <= '0;
            gt_cnt  <= '0;
            lt_cnt  <= '0;
            eq_cnt  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rel_compare_tracker.sv
module tb_rel_compare_tracker;

   localparam int W  = 8;
   localparam int CW = 3;
   localparam int RW = 3 + 2 * W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          clear = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;

   // unsigned instance (CNT_W = 3) -- fully scoreboarded
   logic          u_in_ready, u_out_valid, u_gt, u_lt, u_eq, u_stats_valid;
   logic [W-1:0]  u_max, u_min, u_run_max, u_run_min;
   logic [CW-1:0] u_gt_cnt, u_lt_cnt, u_eq_cnt;

   // signed instance -- directed checks
   logic          s_in_ready, s_out_valid, s_gt, s_lt, s_eq, s_stats_valid;
   logic [W-1:0]  s_max, s_min, s_run_max, s_run_min;
   logic [7:0]    s_gt_cnt, s_lt_cnt, s_eq_cnt;

   int checks = 0;
   int errors = 0;

   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] exp_v;
   logic          e_gt, e_lt, e_eq;
   logic [W-1:0]  e_max, e_min;
   logic [CW-1:0] m_gt, m_lt, m_eq;
   logic [W-1:0]  m_max, m_min;
   logic          m_valid;

   rel_compare_tracker #(.WIDTH(W), .SIGNED(0), .CNT_W(CW)) dut_u (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
      .a(a), .b(b), .clear(clear), .out_valid(u_out_valid), .out_ready(out_ready),
      .gt(u_gt), .lt(u_lt), .eq(u_eq), .max_ab(u_max), .min_ab(u_min),
      .run_max(u_run_max), .run_min(u_run_min), .gt_cnt(u_gt_cnt),
      .lt_cnt(u_lt_cnt), .eq_cnt(u_eq_cnt), .stats_valid(u_stats_valid)
   );

   rel_compare_tracker #(.WIDTH(W), .SIGNED(1), .CNT_W(8)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .a(a), .b(b), .clear(clear), .out_valid(s_out_valid), .out_ready(out_ready),
      .gt(s_gt), .lt(s_lt), .eq(s_eq), .max_ab(s_max), .min_ab(s_min),
      .run_max(s_run_max), .run_min(s_run_min), .gt_cnt(s_gt_cnt),
      .lt_cnt(s_lt_cnt), .eq_cnt(s_eq_cnt), .stats_valid(s_stats_valid)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_val);
      checks++;
      assert (obs === exp_val) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_val);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pair(input logic [W-1:0] x, input logic [W-1:0] y);
      logic acc;
      int   n;
      a = x;
      b = y;
      in_valid = 1'b1;
      n = 0;
      do begin
         acc = u_in_ready;
         step();
         n++;
      end while (!acc && n < 50);
      in_valid = 1'b0;
      check("send_accepted", acc, 1'b1);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   // ---------------- scoreboard monitor (negedge) ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_gt = '0; m_lt = '0; m_eq = '0;
         m_max = '0; m_min = '0; m_valid = 1'b0;
      end else begin
         check("in_ready", u_in_ready, !u_out_valid || out_ready);
         check("out_valid_vs_queue", u_out_valid, exp_q.size() != 0);
         if (u_out_valid && exp_q.size() != 0) begin
            check("onehot", {1'b0, u_gt} + {1'b0, u_lt} + {1'b0, u_eq}, 2'd1);
            check("held_result", {u_gt, u_lt, u_eq, u_max, u_min}, exp_q[0]);
            if (out_ready) exp_v = exp_q.pop_front();
         end
         check("gt_cnt", u_gt_cnt, m_gt);
         check("lt_cnt", u_lt_cnt, m_lt);
         check("eq_cnt", u_eq_cnt, m_eq);
         check("run_max", u_run_max, m_max);
         check("run_min", u_run_min, m_min);
         check("stats_valid", u_stats_valid, m_valid);

         // model update for the coming edge
         if (clear) begin
            m_gt = '0; m_lt = '0; m_eq = '0;
            m_max = '0; m_min = '0; m_valid = 1'b0;
         end
         if (in_valid && u_in_ready) begin
            e_gt  = a > b;
            e_lt  = a < b;
            e_eq  = a == b;
            e_max = e_gt ? a : b;
            e_min = e_gt ? b : a;
            exp_q.push_back({e_gt, e_lt, e_eq, e_max, e_min});
            if (!m_valid) begin
               m_max = e_max;
               m_min = e_min;
            end else begin
               if (e_max > m_max) m_max = e_max;
               if (e_min < m_min) m_min = e_min;
            end
            m_valid = 1'b1;
            if (e_gt && m_gt != 3'd7) m_gt = m_gt + 3'd1;
            if (e_lt && m_lt != 3'd7) m_lt = m_lt + 3'd1;
            if (e_eq && m_eq != 3'd7) m_eq = m_eq + 3'd1;
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      // reset
      repeat (3) step();
      check("rst_out_valid", u_out_valid, 1'b0);
      check("rst_flags", {u_gt, u_lt, u_eq}, 3'b000);
      check("rst_max_min", {u_max, u_min}, 16'h0);
      check("rst_run", {u_run_max, u_run_min}, 16'h0);
      check("rst_cnts", {u_gt_cnt, u_lt_cnt, u_eq_cnt}, 9'h0);
      check("rst_stats_valid", u_stats_valid, 1'b0);
      check("rst_in_ready", u_in_ready, 1'b1);
      rst_n = 1'b1;
      step();

      // single pair
      out_ready = 1'b1;
      send_pair(8'd5, 8'd3);
      check("single_out_valid", u_out_valid, 1'b1);
      check("single_flags", {u_gt, u_lt, u_eq}, 3'b100);
      check("single_max", u_max, 8'd5);
      check("single_min", u_min, 8'd3);
      check("single_gt_cnt", u_gt_cnt, 3'd1);
      check("single_run", {u_run_max, u_run_min}, {8'd5, 8'd3});
      check("single_stats_valid", u_stats_valid, 1'b1);

      // signed vs unsigned on 0x80 / 0x7F
      send_pair(8'h80, 8'h7F);
      check("signed_flags", {s_gt, s_lt, s_eq}, 3'b010);
      check("signed_min", s_min, 8'h80);
      check("signed_max", s_max, 8'h7F);
      check("unsigned_flags", {u_gt, u_lt, u_eq}, 3'b100);
      check("unsigned_max", u_max, 8'h80);
      check("signed_run_min", s_run_min, 8'h80);
      check("signed_run_max", s_run_max, 8'h7F);
      step();

      // backpressure
      do_clear();
      out_ready = 1'b0;
      send_pair(8'd1, 8'd2);
      a = 8'd9;
      b = 8'd9;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready_low", u_in_ready, 1'b0);
         check("bp_held_lt", {u_out_valid, u_gt, u_lt, u_eq}, 4'b1010);
         check("bp_held_vals", {u_max, u_min}, {8'd2, 8'd1});
         step();
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("bp_eq_result", {u_out_valid, u_gt, u_lt, u_eq}, 4'b1001);
      check("bp_eq_vals", {u_max, u_min}, {8'd9, 8'd9});
      check("bp_counts", {u_gt_cnt, u_lt_cnt, u_eq_cnt}, {3'd0, 3'd1, 3'd1});
      step();
      check("bp_drained", u_out_valid, 1'b0);

      // saturation
      do_clear();
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         a = 8'($urandom_range(255, 1));
         b = 8'($urandom_range(int'(a) - 1, 0));
         check("sat_in_ready", u_in_ready, 1'b1);
         step();
         check("sat_out_valid", u_out_valid, 1'b1);
      end
      in_valid = 1'b0;
      check("sat_gt_cnt", u_gt_cnt, 3'd7);
      check("sat_lt_eq_cnt", {u_lt_cnt, u_eq_cnt}, 6'd0);
      check("sat_signed_cnt_total", s_gt_cnt + s_lt_cnt + s_eq_cnt, 8'd10);
      step();

      // clear together with accept
      do_clear();
      send_pair(8'd200, 8'd1);
      send_pair(8'd50, 8'd2);
      send_pair(8'd30, 8'd3);
      send_pair(8'd20, 8'd4);
      check("pre_clear_run_max", u_run_max, 8'd200);
      check("pre_clear_gt_cnt", u_gt_cnt, 3'd4);
      a = 8'd10;
      b = 8'd10;
      in_valid = 1'b1;
      clear = 1'b1;
      step();
      in_valid = 1'b0;
      clear = 1'b0;
      check("clracc_cnts", {u_gt_cnt, u_lt_cnt, u_eq_cnt}, {3'd0, 3'd0, 3'd1});
      check("clracc_run", {u_run_max, u_run_min}, {8'd10, 8'd10});
      check("clracc_stats_valid", u_stats_valid, 1'b1);
      check("clracc_result", {u_out_valid, u_eq}, 2'b11);
      step();

      // asynchronous reset while a result is held
      out_ready = 1'b0;
      send_pair(8'd77, 8'd33);
      check("ar_pre_valid", u_out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_out_valid", u_out_valid, 1'b0);
      check("ar_cnts", {u_gt_cnt, u_lt_cnt, u_eq_cnt}, 9'h0);
      check("ar_stats_valid", u_stats_valid, 1'b0);
      check("ar_run", {u_run_max, u_run_min}, 16'h0);
      check("ar_flags", {u_gt, u_max, u_min}, 17'h0);
      check("ar_signed", {s_out_valid, s_stats_valid, s_gt_cnt}, 10'h0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // random traffic checked by the scoreboard
      for (int i = 0; i < 80; i++) begin
         a = 8'($urandom_range(255, 0));
         b = ($urandom_range(3, 0) == 0) ? a : 8'($urandom_range(255, 0));
         in_valid  = 1'($urandom_range(1, 0));
         out_ready = ($urandom_range(3, 0) != 0);
         clear     = ($urandom_range(15, 0) == 0);
         step();
      end
      in_valid  = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      check("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
